// File: rtl/addsub_pkg.sv
// Shared types for the chunk-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        ADC = 2'b10,
        SBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // SUB and SBC invert the second operand.
    function automatic logic op_is_sub(input op_e op);
        return op[0];
    endfunction

    // Carry into chunk 0: fixed for ADD/SUB, previous committed C for ADC/SBC.
    function automatic logic op_cin(input op_e op, input logic flag_c);
        logic c;
        case (op)
            ADD:     c = 1'b0;
            SUB:     c = 1'b1;
            default: c = flag_c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/chunk_addsub.sv
// One CHUNK-bit slice of the ripple adder, reused every CALC cycle.
module chunk_addsub #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] total;

    // Plain add with carry; carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum   = total[CHUNK-1:0];
        cout  = total[CHUNK];
        cmsb  = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
    end

endmodule

// File: rtl/addsub_serial_unit.sv
// Chunk-serial ADD/SUB/ADC/SBC unit: one CHUNK-wide slice per cycle, result
// and NZCV flags committed together when the last chunk completes.
module addsub_serial_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_e             state, state_next;
    logic               accept;
    logic               last;

    logic [WIDTH-1:0]   a_q, b_q, beff;
    op_e                op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               zacc_q;
    logic [WIDTH-1:0]   acc_q, full_sum;

    logic [CHUNK-1:0]   a_ch, b_ch, sum_ch;
    logic               cout_ch, cmsb_ch;

    assign last = (state == CALC) && (idx_q == IDX_W'(NCH - 1));

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, start acceptance and status outputs.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: if (start) begin
                state_next = CALC;
                accept     = 1'b1;
            end
            CALC: if (last) state_next = DONE;
            DONE: begin
                if (start) begin
                    state_next = CALC;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the current chunk of both operands and merge its sum into the partial word.
    always_comb begin
        beff     = op_is_sub(op_q) ? ~b_q : b_q;
        a_ch     = CHUNK'(a_q  >> (idx_q * CHUNK));
        b_ch     = CHUNK'(beff >> (idx_q * CHUNK));
        full_sum = acc_q;
        for (int k = 0; k < NCH; k++) begin
            if (IDX_W'(k) == idx_q) full_sum[k*CHUNK +: CHUNK] = sum_ch;
        end
    end

    chunk_addsub #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_ch),
        .b    (b_ch),
        .cin  (carry_q),
        .sum  (sum_ch),
        .cout (cout_ch),
        .cmsb (cmsb_ch)
    );

    // Operand capture and partial-sum accumulation; these never reach the outputs directly.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op_e'(op);
            zacc_q <= 1'b1;
        end else if (state == CALC) begin
            acc_q  <= full_sum;
            zacc_q <= zacc_q & ~|sum_ch;
        end
    end

    // Chunk sequencing, inter-chunk carry, and the single commit of result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= op_cin(op_e'(op), flag_c);
        end else if (state == CALC) begin
            carry_q <= cout_ch;
            if (last) begin
                idx_q  <= '0;
                result <= full_sum;
                flag_n <= sum_ch[CHUNK-1];
                flag_z <= zacc_q & ~|sum_ch;
                flag_c <= cout_ch;
                flag_v <= cout_ch ^ cmsb_ch;
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Scoreboard bench for addsub_serial_unit: directed corner cases followed by
// randomized operations, compared against an arithmetic reference model.
module tb_addsub_serial_unit;

    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, flag_n, flag_z, flag_c, flag_v;
    logic [WIDTH-1:0] result;

    addsub_serial_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [3:0]       nzcv;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic model_c = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: unsigned sum gives result and carry, signed sum gives overflow.
    task automatic predict(input logic [1:0] o, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, output exp_t e);
        logic [WIDTH-1:0] be;
        logic             ci;
        int               us, ss;
        be = o[0] ? ~y : y;
        ci = o[1] ? model_c : o[0];
        us = int'(x) + int'(be) + int'(ci);
        ss = int'($signed(x)) + int'($signed(be)) + int'(ci);
        e.res  = us[WIDTH-1:0];
        e.nzcv = {e.res[WIDTH-1], (e.res == '0), us[WIDTH] == 1'b1,
                  (ss > (2**(WIDTH-1) - 1)) || (ss < -(2**(WIDTH-1)))};
        model_c = us[WIDTH];
    endtask

    // Issue a start at the next falling edge; DUT must be in IDLE or DONE then.
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        predict(o, x, y, e);
        e.due = cyc + 1 + NCH;
        sb.push_back(e);
    endtask

    // One operation: scramble inputs while it runs, optionally pulse a start
    // mid-CALC, then idle for gap cycles (gap 0 means the next one is back-to-back).
    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int gap, input bit ign);
        issue(o, x, y);
        for (int i = 0; i < NCH; i++) begin
            @(negedge clk);
            start = (ign && i == 0 && NCH > 1);
            op = 2'($urandom);
            a  = WIDTH'($urandom);
            b  = WIDTH'($urandom);
            if (i == 0) chk("busy_in_calc", {31'd0, busy}, 32'd1);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk(name, {22'd0, busy, done, result}, 32'd0);
        chk({name, "_flags"}, {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    endtask

    // Start an operation and assert reset while it is still computing.
    task automatic reset_mid(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        issue(o, x, y);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        void'(sb.pop_back());
        model_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("after_reset_hold");
    endtask

    // Monitor: every done must match the oldest outstanding expectation on time.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.due);
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("nzcv", {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, e.nzcv});
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("missing_done", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    initial begin
        int waited;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 8'h05, 8'h05, 1, 0);   // SUB equal -> 0, Z C
        run_op(2'b01, 8'h80, 8'h01, 0, 0);   // SUB overflow
        run_op(2'b00, 8'hFF, 8'h01, 1, 0);   // ADD wrap -> Z C
        run_op(2'b00, 8'h0F, 8'h01, 0, 0);   // carry across chunk boundary
        run_op(2'b00, 8'hFF, 8'h01, 0, 0);   // commit C=1
        run_op(2'b10, 8'h7F, 8'h00, 0, 0);   // ADC back-to-back with C=1
        run_op(2'b01, 8'h03, 8'h05, 0, 0);   // commit C=0
        run_op(2'b11, 8'h10, 8'h01, 2, 1);   // SBC with C=0, ignored mid-CALC start
        run_op(2'b00, 8'hFF, 8'h01, 0, 0);   // commit C=1 before the aborted op
        reset_mid(2'b10, 8'h12, 8'h34);
        run_op(2'b11, 8'h10, 8'h01, 1, 0);   // SBC after reset uses C=0
        run_op(2'b01, 8'h03, 8'h05, 1, 0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 24) == 0)
                reset_mid(2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            else
                run_op(2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                       $urandom_range(0, 2), $urandom_range(0, 4) == 0);
        end

        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_serial_unit.md
ADDSUB_SERIAL_UNIT -- requirements
Module: addsub_serial_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, with NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request to begin an operation.
REQ-006 SHALL have port op, input, 2, operation select: ADD=00, SUB=01, ADC=10, SBC=11.
REQ-007 SHALL have ports a and b, input, WIDTH each, operands, two's complement or unsigned.
REQ-008 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a committed result.
REQ-010 SHALL have port result, output, WIDTH, last committed result.
REQ-011 SHALL have ports flag_n, flag_z, flag_c and flag_v, output, 1 each, last committed NZCV flags.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 Transitions SHALL be: IDLE->CALC on start; CALC->DONE after chunk NCH-1; DONE->CALC on start, else DONE->IDLE.
REQ-014 start SHALL be sampled only in IDLE or DONE and SHALL be ignored in CALC, with no queuing and no operand change.
REQ-015 On an accepted start, a, b and op SHALL be captured in internal registers; later input changes SHALL have no effect on that operation.
REQ-016 The effective second operand Beff SHALL be b for ADD/ADC and ~b for SUB/SBC.
REQ-017 Carry-in cin SHALL be 0 for ADD, 1 for SUB, and the committed flag_c value captured at start for ADC/SBC.
REQ-018 Each CALC cycle k (k = 0..NCH-1) SHALL compute bits [k*CHUNK +: CHUNK] of a + Beff + carry, where carry is cin for k = 0 and the registered chunk carry-out of k-1 otherwise.
REQ-019 Latency: for start accepted at edge E0, done SHALL be high in exactly the cycle after edge E_NCH, i.e. NCH cycles after acceptance.
REQ-020 result and flags SHALL update only at the CALC->DONE edge; partial sums SHALL never appear on result.
REQ-021 All outputs SHALL hold their values between commits.
REQ-022 flag_n SHALL equal result[WIDTH-1].
REQ-023 flag_z SHALL be 1 iff all WIDTH result bits are 0, computed with a running zero accumulator across chunks.
REQ-024 flag_c SHALL equal the carry out of bit WIDTH-1 (subtraction convention: C=1 means no borrow).
REQ-025 flag_v SHALL be (a[MSB] == Beff[MSB]) AND (result[MSB] != a[MSB]).
REQ-026 Back-to-back: a start accepted in DONE SHALL enter CALC at the next edge, with done still pulsing for exactly one cycle.
REQ-027 ADC/SBC issued back-to-back SHALL use the flag_c value committed by the immediately preceding operation.

Reset
REQ-028 On rst high, the block SHALL enter IDLE immediately, regardless of clk.
REQ-029 On rst, busy, done, result and all flags SHALL go to 0, and the chunk index and carry SHALL clear.
REQ-030 rst asserted mid-CALC SHALL abort the operation and commit nothing.
REQ-031 After rst deasserts, the first start SHALL behave as a fresh operation, with ADC/SBC using flag_c = 0.

Structure
REQ-032 Package addsub_pkg SHALL hold the op enum (ADD, SUB, ADC, SBC) and the FSM state enum.
REQ-033 A single combinational sub-module chunk_addsub, parametrised by CHUNK, SHALL compute sum, carry-out and carry-into-MSB for one chunk.
REQ-034 The top level SHALL instantiate chunk_addsub once and reuse it every CALC cycle.

Verification (WIDTH=8, CHUNK=4)
REQ-035 SUB with a=0x05, b=0x05 -> result 0x00, N=0 Z=1 C=1 V=0; done asserted 2 cycles after the start edge.
REQ-036 SUB with a=0x80, b=0x01 -> result 0x7F, N=0 Z=0 C=1 V=1; ADD with a=0xFF, b=0x01 -> result 0x00, Z=1 C=1 V=0.
REQ-037 ADD with a=0x0F, b=0x01 -> result 0x10, confirming carry crosses the chunk boundary; then ADC with a=0x7F, b=0x00 after a C=1 commit -> result 0x80, N=1 V=1.
REQ-038 SBC with a=0x10, b=0x01 and committed C=0 -> result 0x0E, C=1; a start pulsed during CALC is ignored and operands are unchanged.
REQ-039 rst asserted in the middle of CALC -> busy, done, result and flags are 0 at once; no done pulse follows; the next SUB with a=0x03, b=0x05 -> result 0xFE, N=1 C=0.
